// File: rtl/shift_issue_if.sv
// Bundles the decode-side, shift-unit-side and writeback-side signals of shift_issue.
// The slave modport is the issue controller. The master modport is its environment:
// decode, the shift unit and writeback.
interface shift_issue_if;
  // decode -> issue
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic        in_is_imm;
  logic [31:0] in_rs1_val;
  logic [31:0] in_rs2_val;
  logic [31:0] in_imm;
  logic [4:0]  in_rd;
  // issue <-> shift unit
  logic        sh_start;
  logic [31:0] sh_op1;
  logic [31:0] sh_op2;
  logic [31:0] sh_imm_data;
  logic [1:0]  sh_use_part;
  logic [1:0]  sh_op_mode1;
  logic [2:0]  sh_op_mode2;
  logic        sh_done;
  logic [31:0] sh_res;
  // issue -> writeback
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_err;

  modport slave (
    input  in_valid, in_funct3, in_funct7, in_is_imm, in_rs1_val, in_rs2_val, in_imm, in_rd,
    output in_ready,
    output sh_start, sh_op1, sh_op2, sh_imm_data, sh_use_part, sh_op_mode1, sh_op_mode2,
    input  sh_done, sh_res,
    output wb_valid, wb_rd, wb_data, wb_err,
    input  wb_ready
  );

  modport master (
    output in_valid, in_funct3, in_funct7, in_is_imm, in_rs1_val, in_rs2_val, in_imm, in_rd,
    input  in_ready,
    input  sh_start, sh_op1, sh_op2, sh_imm_data, sh_use_part, sh_op_mode1, sh_op_mode2,
    output sh_done, sh_res,
    input  wb_valid, wb_rd, wb_data, wb_err,
    output wb_ready
  );
endinterface

// File: rtl/shift_issue.sv
// shift_issue: issue-side controller for the iterative shift unit.
// It accepts one RV32I shift instruction at a time, validates the encoding and starts the
// shift unit. It then waits for the unit's done pulse and hands the result to writeback.
// Optional feature: define SHIFT_ISSUE_TIMEOUT_EN to bound WAIT to TIMEOUT cycles.
// On expiry the instruction retires with wb_err set.
module shift_issue #(
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  shift_issue_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;

  localparam logic [2:0] MODE2_SLL = 3'b001;
  localparam logic [2:0] MODE2_SRL = 3'b010;
  localparam logic [2:0] MODE2_SRA = 3'b100;

  state_t      state, state_next;
  logic        accept;
  logic        dec_legal;
  logic [2:0]  dec_mode2;
  logic        timeout_hit;

  logic [31:0] op1_q, op2_q, imm_q, wb_data_q;
  logic [1:0]  mode1_q;
  logic [2:0]  mode2_q;
  logic [4:0]  rd_q;
  logic        wb_err_q;

  // Only shamt[4:0] reaches the unit. The upper operand bits are intentionally dropped.
  logic unused_hi;
  assign unused_hi = ^{bus.in_rs2_val[31:5], bus.in_imm[31:5]};

  assign accept = bus.in_valid && (state == S_IDLE);

  // Decode funct3/funct7 into a legal flag and the shift-unit mode.
  // funct7[0] is shamt[5], so any non-zero value in it is illegal on RV32.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    dec_legal = 1'b0;
    dec_mode2 = 3'b000;
    if (bus.in_funct3 == 3'b001 && bus.in_funct7 == 7'b0000000) begin
      dec_legal = 1'b1;
      dec_mode2 = MODE2_SLL;
    end else if (bus.in_funct3 == 3'b101 && bus.in_funct7 == 7'b0000000) begin
      dec_legal = 1'b1;
      dec_mode2 = MODE2_SRL;
    end else if (bus.in_funct3 == 3'b101 && bus.in_funct7 == 7'b0100000) begin
      dec_legal = 1'b1;
      dec_mode2 = MODE2_SRA;
    end
  end

`ifdef SHIFT_ISSUE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Count the cycles spent in WAIT. The count restarts from zero on every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  wait_cnt <= '0;
    else if (state != S_WAIT) wait_cnt <= '0;
    else                      wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout_hit = (state == S_WAIT) && (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic. A completing done has priority over a timeout on the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = dec_legal ? S_ISSUE : S_WB;
      S_ISSUE: state_next = S_WAIT;
      S_WAIT:  if (bus.sh_done || timeout_hit) state_next = S_WB;
      S_WB:    if (bus.wb_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Capture the instruction fields on accept, and the result (or error) when WAIT ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op1_q     <= '0;
      op2_q     <= '0;
      imm_q     <= '0;
      mode1_q   <= '0;
      mode2_q   <= '0;
      rd_q      <= '0;
      wb_data_q <= '0;
      wb_err_q  <= 1'b0;
    end else if (accept) begin
      op1_q     <= bus.in_rs1_val;
      op2_q     <= {27'b0, bus.in_rs2_val[4:0]};
      imm_q     <= {27'b0, bus.in_imm[4:0]};
      mode1_q   <= bus.in_is_imm ? 2'b10 : 2'b00;
      mode2_q   <= dec_mode2;
      rd_q      <= bus.in_rd;
      wb_data_q <= '0;
      wb_err_q  <= ~dec_legal;
    end else if (state == S_WAIT && bus.sh_done) begin
      wb_data_q <= bus.sh_res;
      wb_err_q  <= 1'b0;
    end else if (timeout_hit) begin
      wb_data_q <= '0;
      wb_err_q  <= 1'b1;
    end
  end

  // Outputs decoded from the state. The sh_* outputs are forced to zero while idle.
  assign bus.in_ready    = (state == S_IDLE);
  assign bus.sh_start    = (state == S_ISSUE);
  assign bus.sh_use_part = (state == S_IDLE) ? 2'b00 : 2'b01;
  assign bus.sh_op1      = (state == S_IDLE) ? '0 : op1_q;
  assign bus.sh_op2      = (state == S_IDLE) ? '0 : op2_q;
  assign bus.sh_imm_data = (state == S_IDLE) ? '0 : imm_q;
  assign bus.sh_op_mode1 = (state == S_IDLE) ? '0 : mode1_q;
  assign bus.sh_op_mode2 = (state == S_IDLE) ? '0 : mode2_q;
  assign bus.wb_valid    = (state == S_WB);
  assign bus.wb_rd       = rd_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.wb_err      = wb_err_q;

endmodule

// File: tb/tb_shift_issue.sv
// Testbench for shift_issue. The directed vectors come from a table with hand-derived
// results. Random instructions are checked against an arithmetic reference model.
// The shift unit is emulated by the bench. Inputs are driven and outputs sampled on the
// falling clock edge.
module tb_shift_issue;

  localparam int TB_TIMEOUT = 8;

  typedef struct {
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        is_imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [31:0] exp_data;
    logic        exp_err;
    logic [2:0]  exp_mode2;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   start_cnt = 0;

  shift_issue_if bus ();

  shift_issue #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Count every start pulse the DUT issues.
  always @(posedge clk) if (bus.sh_start === 1'b1) start_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Emulated shift unit: it computes the shift from the operands the DUT presents.
  function automatic logic [31:0] shift_unit(input logic [31:0] op1, input logic [31:0] op2,
                                             input logic [31:0] imm, input logic [1:0] m1,
                                             input logic [2:0] m2);
    int amt;
    amt = (m1 == 2'b10) ? int'(imm[4:0]) : int'(op2[4:0]);
    case (m2)
      3'b001:  return op1 << amt;
      3'b010:  return op1 >> amt;
      3'b100:  return $unsigned($signed(op1) >>> amt);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Reference model: the architectural result, taken straight from the ISA rules.
  function automatic vec_t ref_model(input vec_t v);
    vec_t        r;
    int unsigned amt;
    longint      s;
    r   = v;
    amt = v.is_imm ? v.imm % 32 : v.rs2 % 32;
    s   = longint'($signed(v.rs1));
    r.exp_err   = 1'b0;
    r.exp_mode2 = 3'b000;
    if (v.f3 == 3'd1 && v.f7 == 7'd0) begin
      r.exp_data  = 32'(longint'(v.rs1) * (longint'(1) << amt));
      r.exp_mode2 = 3'b001;
    end else if (v.f3 == 3'd5 && v.f7 == 7'd0) begin
      r.exp_data  = 32'(longint'(v.rs1) / (longint'(1) << amt));
      r.exp_mode2 = 3'b010;
    end else if (v.f3 == 3'd5 && v.f7 == 7'h20) begin
      // Arithmetic shift right is floor division of the signed value.
      r.exp_data  = (s >= 0) ? 32'(s / (longint'(1) << amt))
                             : 32'(-((-s + (longint'(1) << amt) - 1) / (longint'(1) << amt)));
      r.exp_mode2 = 3'b100;
    end else begin
      r.exp_data = 32'd0;
      r.exp_err  = 1'b1;
    end
    return r;
  endfunction

  task automatic drive_in(input vec_t v);
    bus.in_valid   = 1'b1;
    bus.in_funct3  = v.f3;
    bus.in_funct7  = v.f7;
    bus.in_is_imm  = v.is_imm;
    bus.in_rs1_val = v.rs1;
    bus.in_rs2_val = v.rs2;
    bus.in_imm     = v.imm;
    bus.in_rd      = v.rd;
  endtask

  // Run one instruction end to end. done_dly adds extra WAIT cycles before the done
  // pulse, and bp is the number of cycles writeback is held off.
  task automatic run_instr(input vec_t v, input int done_dly, input int bp);
    int          s0;
    logic [31:0] d, exp_op2, exp_imm;
    logic [1:0]  exp_m1;
    logic        e;
    exp_op2 = {27'b0, v.rs2[4:0]};
    exp_imm = {27'b0, v.imm[4:0]};
    exp_m1  = v.is_imm ? 2'b10 : 2'b00;
    @(negedge clk);
    check("in_ready_idle", bus.in_ready, 1);
    drive_in(v);
    s0 = start_cnt;
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (!v.exp_err) begin
      check("issue_start", bus.sh_start, 1);
      check("issue_op1", bus.sh_op1, v.rs1);
      check("issue_op2", bus.sh_op2, exp_op2);
      check("issue_imm", bus.sh_imm_data, exp_imm);
      check("issue_mode1", bus.sh_op_mode1, exp_m1);
      check("issue_mode2", bus.sh_op_mode2, v.exp_mode2);
      check("issue_part", bus.sh_use_part, 2'b01);
      for (int i = 0; i <= done_dly; i++) begin
        @(negedge clk);
        check("wait_no_start", bus.sh_start, 0);
        check("wait_no_wb", bus.wb_valid, 0);
        check("wait_op1_stable", bus.sh_op1, v.rs1);
        check("wait_op2_stable", bus.sh_op2, exp_op2);
        check("wait_imm_stable", bus.sh_imm_data, exp_imm);
      end
      bus.sh_done = 1'b1;
      bus.sh_res  = shift_unit(bus.sh_op1, bus.sh_op2, bus.sh_imm_data,
                               bus.sh_op_mode1, bus.sh_op_mode2);
      @(negedge clk);
      bus.sh_done = 1'b0;
      bus.sh_res  = $urandom;
    end else begin
      check("illegal_no_start", bus.sh_start, 0);
    end
    check("wb_valid", bus.wb_valid, 1);
    check("wb_err", bus.wb_err, v.exp_err);
    check("wb_data", bus.wb_data, v.exp_data);
    check("wb_rd", bus.wb_rd, v.rd);
    check("start_count", start_cnt - s0, v.exp_err ? 0 : 1);
    d = bus.wb_data;
    e = bus.wb_err;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("bp_valid", bus.wb_valid, 1);
      check("bp_data", bus.wb_data, d);
      check("bp_err", bus.wb_err, e);
      check("bp_rd", bus.wb_rd, v.rd);
      check("bp_in_ready", bus.in_ready, 0);
    end
    bus.wb_ready = 1'b1;
    @(negedge clk);
    bus.wb_ready = 1'b0;
    check("post_wb_valid", bus.wb_valid, 0);
    check("post_wb_in_ready", bus.in_ready, 1);
  endtask

  initial begin
    vec_t tbl[5];
    vec_t v;
    int   s0;

    // Directed vectors with hand-derived expectations.
    tbl[0] = '{3'b101, 7'h20, 1'b0, 32'h9000_0000, 32'h0000_0002, 32'h0, 5'd7,
               32'hE400_0000, 1'b0, 3'b100};                       // SRA
    tbl[1] = '{3'b101, 7'h00, 1'b1, 32'h9000_0000, 32'hFFFF_FFFF, 32'h3, 5'd9,
               32'h1200_0000, 1'b0, 3'b010};                       // SRLI
    tbl[2] = '{3'b001, 7'h00, 1'b0, 32'h0000_0001, 32'h0000_0025, 32'h1F, 5'd0,
               32'h0000_0020, 1'b0, 3'b001};                       // SLL, rd = 0
    tbl[3] = '{3'b010, 7'h00, 1'b0, 32'h1234_5678, 32'h1, 32'h1, 5'd3,
               32'h0, 1'b1, 3'b000};                               // illegal funct3
    tbl[4] = '{3'b001, 7'h01, 1'b1, 32'h1234_5678, 32'h1, 32'h21, 5'd4,
               32'h0, 1'b1, 3'b000};                               // SLLI with shamt[5] set

    bus.in_valid = 1'b0; bus.in_funct3 = '0; bus.in_funct7 = '0; bus.in_is_imm = 1'b0;
    bus.in_rs1_val = '0; bus.in_rs2_val = '0; bus.in_imm = '0; bus.in_rd = '0;
    bus.sh_done = 1'b0; bus.sh_res = '0; bus.wb_ready = 1'b0;

    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_start", bus.sh_start, 0);
    check("rst_part", bus.sh_use_part, 0);
    check("rst_op1", bus.sh_op1, 0);
    check("rst_mode2", bus.sh_op_mode2, 0);
    check("rst_wb_valid", bus.wb_valid, 0);
    check("rst_wb_data", bus.wb_data, 0);
    check("rst_wb_err", bus.wb_err, 0);
    check("rst_wb_rd", bus.wb_rd, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_instr(tbl[i], i % 3, (i == 0) ? 5 : 1);

    // A done pulse while idle must be ignored.
    @(negedge clk);
    s0 = start_cnt;
    bus.sh_done = 1'b1;
    bus.sh_res  = 32'hA5A5_A5A5;
    @(negedge clk);
    bus.sh_done = 1'b0;
    check("stray_done_wb", bus.wb_valid, 0);
    check("stray_done_ready", bus.in_ready, 1);
    check("stray_done_start", start_cnt - s0, 0);

    // Random instructions against the reference model.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       v.f3 = 3'b001;
        1, 2:    v.f3 = 3'b101;
        default: v.f3 = 3'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0, 1:    v.f7 = 7'h00;
        2:       v.f7 = 7'h20;
        default: v.f7 = 7'($urandom);
      endcase
      v.is_imm = 1'($urandom);
      v.rs1    = $urandom;
      v.rs2    = $urandom;
      v.imm    = $urandom;
      v.rd     = 5'($urandom);
      v = ref_model(v);
      run_instr(v, $urandom_range(0, 4), $urandom_range(0, 3));
    end

    // Asynchronous reset in WAIT aborts at once, and no writeback follows.
    v = ref_model('{3'b001, 7'h00, 1'b0, 32'h0000_00FF, 32'h4, 32'h0, 5'd1,
                    32'h0, 1'b0, 3'b000});
    @(negedge clk);
    drive_in(v);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_wait_in_ready", bus.in_ready, 1);
    check("rst_wait_wb_valid", bus.wb_valid, 0);
    check("rst_wait_part", bus.sh_use_part, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_wait_no_wb", bus.wb_valid, 0);
    end

    // Behaviour when the shift unit never answers.
    @(negedge clk);
    drive_in(v);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("to_start", bus.sh_start, 1);
`ifdef SHIFT_ISSUE_TIMEOUT_EN
    for (int i = 1; i <= TB_TIMEOUT; i++) begin
      @(negedge clk);
      check("to_waiting", bus.wb_valid, 0);
    end
    @(negedge clk);
    check("to_wb_valid", bus.wb_valid, 1);
    check("to_wb_err", bus.wb_err, 1);
    check("to_wb_data", bus.wb_data, 0);
    bus.sh_done = 1'b1;
    bus.sh_res  = 32'h1234_5678;
    @(negedge clk);
    bus.sh_done = 1'b0;
    check("late_done_data", bus.wb_data, 0);
    check("late_done_err", bus.wb_err, 1);
    check("late_done_valid", bus.wb_valid, 1);
`else
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      check("no_to_waiting", bus.wb_valid, 0);
    end
    bus.sh_done = 1'b1;
    bus.sh_res  = 32'h0000_FF00;
    @(negedge clk);
    bus.sh_done = 1'b0;
    check("no_to_valid", bus.wb_valid, 1);
    check("no_to_err", bus.wb_err, 0);
    check("no_to_data", bus.wb_data, 32'h0000_FF00);
`endif
    bus.wb_ready = 1'b1;
    @(negedge clk);
    bus.wb_ready = 1'b0;
    check("end_idle", bus.in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_issue.md
# shift_issue

Issue-side controller for the iterative shift unit in the RV052B execute stage. It accepts decoded RV32I shift instructions (SLL/SRL/SRA and SLLI/SRLI/SRAI) from decode over a valid/ready handshake and validates the encoding. It drives the shift unit's start/operand/mode interface, waits for its `done`, and returns the result with the destination register to writeback over a second valid/ready handshake. One instruction is in flight at a time.

## Interface
- `TIMEOUT`, 64: maximum WAIT cycles before abort; used only with the timeout feature.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: decode offers an instruction.
- `in_ready` out 1: accepted when `in_valid & in_ready`.
- `in_funct3` in 3: instr[14:12].
- `in_funct7` in 7: instr[31:25], for both R- and I-type.
- `in_is_imm` in 1: 1 = I-type (SLLI/SRLI/SRAI).
- `in_rs1_val` in 32: value to shift.
- `in_rs2_val` in 32: shift amount source (R-type).
- `in_imm` in 32: immediate; shamt in [4:0] (I-type).
- `in_rd` in 5: destination register.
- `sh_start` out 1: one-cycle start pulse to the shift unit.
- `sh_op1`, `sh_op2`, `sh_imm_data` out 32 each: shift unit operands.
- `sh_use_part` out 2: unit select; `01` = shifter.
- `sh_op_mode1` out 2: `00` = shamt from `op2`, `10` = shamt from `imm_data`.
- `sh_op_mode2` out 3: `001` = SLL, `010` = SRL, `100` = SRA.
- `sh_done` in 1: shift unit completion, one-cycle pulse.
- `sh_res` in 32: shift result, valid when `sh_done` = 1.
- `wb_valid` out 1: result offered to writeback.
- `wb_ready` in 1: writeback accepts.
- `wb_rd` out 5: destination register.
- `wb_data` out 32: result.
- `wb_err` out 1: illegal encoding or timeout; `wb_data` = 0 when set.

## Operation
- FSM states:
  - IDLE: `in_ready` = 1.
    - On accept with a legal encoding: latch all fields, go to ISSUE.
    - On accept with an illegal encoding: set `wb_err` = 1, `wb_data` = 0, go to WB. No start is issued.
  - ISSUE: `sh_start` = 1 for exactly this cycle, go to WAIT.
  - WAIT: on `sh_done`, capture `sh_res` into `wb_data` and go to WB.
  - WB: `wb_valid` = 1. On `wb_ready`, go to IDLE.
- Legal encodings:
  - funct3 = 001 with funct7 = 0000000 → SLL.
  - funct3 = 101 with funct7 = 0000000 → SRL.
  - funct3 = 101 with funct7 = 0100000 → SRA.
  - Everything else is illegal. This includes RV32 shamt[5] = 1 (funct7[0]).
- Operand rules:
  - `sh_op1` = rs1.
  - `sh_op2` = {27'b0, rs2[4:0]}.
  - `sh_imm_data` = {27'b0, imm[4:0]}.
  - `sh_op_mode1` = `10` if `in_is_imm`, else `00`.
  - `sh_use_part` = `01` whenever the FSM is not in IDLE.
- `sh_op*` outputs are held stable from ISSUE until the FSM leaves WAIT.
- `sh_done` is ignored outside WAIT.
- rd = 0 is still executed and written back; the consumer discards it.
- Outputs in IDLE: `sh_*` = 0, `wb_valid` = 0.

## Timing
- Reset values: all outputs 0 except `in_ready` = 1; state = IDLE.
- Asynchronous reset mid-operation aborts immediately. No writeback follows. The shift unit shares `rst`.
- Latency:
  - Accept at edge N → `sh_start` high during cycle N+1.
  - `sh_done` sampled at edge M → `wb_valid` high from cycle M+1.
  - Illegal encoding → `wb_valid` at N+1.
- `wb_valid`, `wb_rd`, `wb_data` and `wb_err` stay stable until `wb_ready`.
- Next accept is at earliest the cycle after the WB handshake.

## Configuration
- `SHIFT_ISSUE_TIMEOUT_EN` defined:
  - A counter runs in WAIT.
  - If `TIMEOUT` cycles elapse without `sh_done`, go to WB with `wb_err` = 1 and `wb_data` = 0.
  - A late `sh_done` is ignored.
- Not defined:
  - WAIT has no bound.
  - `wb_err` is set only for illegal encodings.
  - No counter is synthesized.

## Test plan
- SRA: rs1 = 0x9000_0000, rs2 = 0x0000_0002.
  - Expect `sh_start` one cycle with `op_mode1` = `00`, `op_mode2` = `100`.
  - Expect `wb_data` = 0xE400_0000 and `wb_err` = 0.
- SRLI: rs1 = 0x9000_0000, imm = 3.
  - Expect `op_mode1` = `10`, `op_mode2` = `010`, `imm_data` = 3.
  - Expect `wb_data` = 0x1200_0000.
- SLL with rs2 = 0x25, rs1 = 1.
  - Expect `sh_op2` = 5 and `wb_data` = 0x0000_0020.
- Illegal encodings: funct3 = 010, then SLLI with funct7 = 0000001.
  - Expect no `sh_start`, `wb_valid` the next cycle, `wb_err` = 1, `wb_data` = 0.
- Backpressure and stray done:
  - Hold `wb_ready` = 0 for 5 cycles. `wb_*` must stay stable and `in_ready` must stay 0.
  - Pulse `sh_done` while the FSM is in IDLE. Expect no effect.
  - Assert `rst` during WAIT. Expect IDLE, `wb_valid` = 0, and no writeback.
- With `SHIFT_ISSUE_TIMEOUT_EN` defined and `TIMEOUT` = 8, never assert `sh_done`.
  - Expect `wb_valid` with `wb_err` = 1 eight cycles after entering WAIT.
  - Expect a late `sh_done` to be ignored.
